fas_serial: RTL and testbench

Bit-serial N-bit adder/subtractor: the sequential counterpart of the single-bit full adder/subtractor cell. It accepts a pair of N-bit operands and an add/subtract control with a start pulse. It processes one bit per clock, LSB first, through one full adder/subtractor slice and a carry flip-flop. It returns the N-bit result, carry-out and optional signed overflow with a one-cycle done strobe. It serves as the area-minimal arithmetic unit for datapaths that tolerate N-cycle latency.

---
 rtl/fas_serial_pkg.sv | 16 +
 rtl/fas_bit.sv | 17 +
 rtl/fas_serial.sv | 157 +++++++++++++++
 tb/tb_fas_serial.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fas_serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package fas_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FAS_SERIAL_DEFAULT_N = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fas_bit.sv
// One-bit full adder/subtractor slice; B is inverted internally when a_ns=0.
module fas_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic bx;

    assign bx   = b ^ ~a_ns;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/fas_serial.sv
// Bit-serial N-bit adder/subtractor, LSB first, one bit per clock.
// Define FAS_SERIAL_OVF_EN to enable signed-overflow detection on ovf.
module fas_serial
    import fas_serial_pkg::*;
#(
    parameter int N = FAS_SERIAL_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         a_ns,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cnt_width(N);

    state_t         state_q, state_d;
    logic [N-1:0]   a_sr_q, a_sr_d;
    logic [N-1:0]   b_sr_q, b_sr_d;
    logic [N-2:0]   res_q, res_d;
    logic [N-1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_q, op_d;
    logic           c_q, c_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           bit_s, bit_cout;
    logic           last_bit;

    fas_bit u_bit (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .a_ns (op_q),
        .s    (bit_s),
        .cout (bit_cout)
    );

    assign last_bit = (cnt_q == CW'(N - 1));

`ifdef FAS_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef FAS_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = a_ns;
                    c_d     = ~a_ns;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // res holds the N-1 bits already produced; the final sum bit joins them at the MSB
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = (res_q >> 1) | ((N-1)'(bit_s) << (N - 2));
                c_d    = bit_cout;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    s_d     = {bit_s, res_q};
                    cout_d  = bit_cout;
`ifdef FAS_SERIAL_OVF_EN
                    ovf_d   = c_q ^ bit_cout;
`endif
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef FAS_SERIAL_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_fas_serial.sv
// Randomized and directed checks of fas_serial (N=8) against an arithmetic reference model.
module tb_fas_serial;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         a_ns;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int check_count = 0;
    int pass_count  = 0;

    fas_serial #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .a_ns  (a_ns),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {ovf, cout, s} from plain integer arithmetic
    function automatic logic [9:0] refModel(input logic [7:0] x, input logic [7:0] y, input logic add_op);
        int  ux, uy, sx, sy, r, sr;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (add_op) begin
            r  = ux + uy;
            sr = sx + sy;
            c  = (r > 255);
        end else begin
            r  = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end
        v = (sr > 127) || (sr < -128);
`ifndef FAS_SERIAL_OVF_EN
        v = 1'b0;
`endif
        return {v, c, 8'(r)};
    endfunction

    task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_add);
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        a_ns  = op_add;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        a_ns  = 1'($urandom);
    endtask

    task automatic waitDone(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic runAndCheck(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_add, input string tag);
        logic [9:0] exp;
        int lat, busy_cnt;
        exp = refModel(op_a, op_b, op_add);
        applyStimulus(op_a, op_b, op_add);
        waitDone(lat, busy_cnt);
        checkOutput({tag, "_latency"}, lat, 8);
        checkOutput({tag, "_s"}, s, exp[7:0]);
        checkOutput({tag, "_cout"}, cout, exp[8]);
        checkOutput({tag, "_ovf"}, ovf, exp[9]);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 0);
        checkOutput({tag, "_busy_cnt"}, busy_cnt + (busy ? 1 : 0), 9);
        checkOutput({tag, "_s_hold"}, s, exp[7:0]);
    endtask

    logic [7:0] dir_a  [6] = '{8'd100, 8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80};
    logic [7:0] dir_b  [6] = '{8'd27,  8'h01, 8'h07, 8'h05, 8'h01, 8'h01};
    logic       dir_op [6] = '{1'b1,   1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

    initial begin
        int lat, busy_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        a_ns  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_s", s, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            runAndCheck(dir_a[i], dir_b[i], dir_op[i], $sformatf("dir%0d", i));
        end

        // A start pulse mid-operation must not disturb the running add
        applyStimulus(8'h10, 8'h20, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; a_ns = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat, busy_cnt);
        checkOutput("ignore_latency", lat, 5);
        checkOutput("ignore_s", s, 8'h30);
        checkOutput("ignore_cout", cout, 0);
        start = 1'b1; a = 8'h03; b = 8'h04; a_ns = 1'b1;
        @(negedge clk);
        checkOutput("done_cycle_start_busy", busy, 0);
        @(negedge clk);
        checkOutput("after_done_start_busy", busy, 1);
        start = 1'b0;
        waitDone(lat, busy_cnt);
        checkOutput("after_done_latency", lat, 8);
        checkOutput("after_done_s", s, 8'h07);

        for (int i = 0; i < 25; i++) begin
            runAndCheck(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        runAndCheck(8'h0F, 8'h0F, 1'b1, "pre_reset");
        applyStimulus(8'h33, 8'h44, 1'b1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_s", s, 0);
        checkOutput("midrst_cout", cout, 0);
        checkOutput("midrst_ovf", ovf, 0);
        begin
            int seen_done;
            seen_done = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) seen_done++;
            end
            rst_n = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (done) seen_done++;
            end
            checkOutput("midrst_no_done", seen_done, 0);
            checkOutput("midrst_idle_busy", busy, 0);
        end
        runAndCheck(8'h01, 8'h01, 1'b1, "post_reset");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
